// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with in-flight tracking and 2-entry output FIFO

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef logDepthMem
`define logDepthMem 8
`endif

module fetch_stage #(
  parameter int                   WIDTH     = `INSTR_WIDTH,
  parameter int                   LOG_DEPTH = `logDepthMem,
  parameter logic [LOG_DEPTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [LOG_DEPTH-1:0] instrAddress,
  input  logic [WIDTH-1:0]     instr,
  input  logic                 redirect_valid,
  input  logic [LOG_DEPTH-1:0] redirect_addr,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [WIDTH-1:0]     if_instr,
  output logic [LOG_DEPTH-1:0] if_pc
);

  // Fetch-side state: next address to issue and the single outstanding read.
  logic [LOG_DEPTH-1:0] pc;
  logic                 infl;
  logic [LOG_DEPTH-1:0] infl_pc;

  // Output FIFO: head entry drives the outputs, tail is the overflow slot.
  logic [1:0]           count;
  logic [WIDTH-1:0]     head_instr;
  logic [LOG_DEPTH-1:0] head_pc;
  logic [WIDTH-1:0]     tail_instr;
  logic [LOG_DEPTH-1:0] tail_pc;

  logic                 pop;
  logic                 capture;
  logic                 issue;
  logic [1:0]           count_after_pop;
  logic [2:0]           occupancy;

  // Occupancy counts the entry leaving this edge as free, so a full pipe
  // with decode draining every cycle keeps issuing one fetch per cycle.
  always_comb begin
    pop             = (count != 2'd0) && if_ready;
    capture         = infl;
    count_after_pop = count - {1'b0, pop};
    occupancy       = {1'b0, count_after_pop} + {2'b00, infl};
    issue           = !redirect_valid && (occupancy < 3'd2);
  end

  assign instrAddress = pc;
  assign if_valid     = (count != 2'd0);
  assign if_instr     = head_instr;
  assign if_pc        = head_pc;

  // PC and in-flight tracking; a redirect squashes the outstanding read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= '0;
    end else if (redirect_valid) begin
      pc   <= redirect_addr;
      infl <= 1'b0;
    end else if (issue) begin
      pc      <= pc + LOG_DEPTH'(1);
      infl    <= 1'b1;
      infl_pc <= pc;
    end else begin
      infl <= 1'b0;
    end
  end

  // FIFO update: pop shifts tail into head, capture lands in the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      if (capture && (count_after_pop == 2'd0)) begin
        head_instr <= instr;
        head_pc    <= infl_pc;
      end else if (pop) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
      end
      if (capture && (count_after_pop == 2'd1)) begin
        tail_instr <= instr;
        tail_pc    <= infl_pc;
      end
      count <= count_after_pop + {1'b0, capture};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven and scoreboard bench for fetch_stage

module tb_fetch_stage;

  localparam int W  = 16;
  localparam int LD = 6;

  logic          clk;
  logic          rst;
  logic          redirect_valid;
  logic [LD-1:0] redirect_addr;
  logic          if_ready;

  logic [LD-1:0] addr_a, addr_b;
  logic [W-1:0]  instr_a, instr_b;
  logic          if_valid, valid_b;
  logic [W-1:0]  if_instr, instr_out_b;
  logic [LD-1:0] if_pc, pc_b;

  fetch_stage #(.WIDTH(W), .LOG_DEPTH(LD), .RESET_PC(6'h00)) dut (
    .clk(clk), .rst(rst), .instrAddress(addr_a), .instr(instr_a),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  fetch_stage #(.WIDTH(W), .LOG_DEPTH(LD), .RESET_PC(6'h3f)) dut_b (
    .clk(clk), .rst(rst), .instrAddress(addr_b), .instr(instr_b),
    .redirect_valid(1'b0), .redirect_addr(6'h00),
    .if_valid(valid_b), .if_ready(1'b1), .if_instr(instr_out_b), .if_pc(pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // i_mem models: mem[k] = k + 0x100, synchronous read
  always @(posedge clk) begin
    instr_a <= W'(addr_a) + 16'h0100;
    instr_b <= W'(addr_b) + 16'h0100;
  end

  typedef struct {
    logic          ready;
    logic          redir;
    logic [LD-1:0] raddr;
    logic          exp_valid;
    logic [LD-1:0] exp_pc;
    logic [LD-1:0] exp_addr;
    logic          chk_b;
    logic [LD-1:0] exp_pc_b;
  } vec_t;

  vec_t          vecs[$];
  logic [LD-1:0] sb[$];
  int            tests = 0;
  int            fails = 0;

  function automatic logic [W-1:0] mem_val(input logic [LD-1:0] a);
    return W'(a) + 16'h0100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic load_stream(input logic [LD-1:0] start);
    logic [LD-1:0] a;
    sb.delete();
    a = start;
    for (int k = 0; k < 64; k++) begin
      sb.push_back(a);
      a = a + 6'd1;
    end
  endtask

  task automatic add(input logic r, input logic rd, input logic [LD-1:0] ra,
                     input logic ev, input logic [LD-1:0] ep, input logic [LD-1:0] ea,
                     input logic cb, input logic [LD-1:0] epb);
    vec_t v;
    v.ready = r; v.redir = rd; v.raddr = ra; v.exp_valid = ev;
    v.exp_pc = ep; v.exp_addr = ea; v.chk_b = cb; v.exp_pc_b = epb;
    vecs.push_back(v);
  endtask

  // Called at a negedge with inputs set; scores the transfer of the next edge.
  task automatic step();
    logic [LD-1:0] e;
    if (rst && if_valid && if_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got transfer pc %h, want none", if_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", 32'(if_pc), 32'(e));
        check("sb_instr", 32'(if_instr), 32'(mem_val(e)));
      end
    end
    if (redirect_valid) load_stream(redirect_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    #2 rst = 1'b0;

    //   rdy rdir raddr  vld pc     addr   chkb pcb
    add(1, 0, 6'h00, 0, 6'h00, 6'h01, 0, 6'h00);  // edge 1
    add(1, 0, 6'h00, 1, 6'h00, 6'h02, 1, 6'h3f);  // edge 2: first valid
    add(1, 0, 6'h00, 1, 6'h01, 6'h03, 1, 6'h00);
    add(1, 0, 6'h00, 1, 6'h02, 6'h04, 1, 6'h01);
    add(1, 0, 6'h00, 1, 6'h03, 6'h05, 0, 6'h00);
    for (int i = 0; i < 5; i++)
      add(0, 0, 6'h00, 1, 6'h03, 6'h05, 0, 6'h00);  // stall: fifo fills, holds
    add(1, 0, 6'h00, 1, 6'h04, 6'h06, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h05, 6'h07, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h06, 6'h08, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h07, 6'h09, 0, 6'h00);
    add(0, 0, 6'h00, 1, 6'h07, 6'h09, 0, 6'h00);  // count -> 2
    add(0, 0, 6'h00, 1, 6'h07, 6'h09, 0, 6'h00);
    add(1, 1, 6'h20, 0, 6'h00, 6'h20, 0, 6'h00);  // redirect with full fifo
    add(1, 0, 6'h00, 0, 6'h00, 6'h21, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h20, 6'h22, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h21, 6'h23, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h22, 6'h24, 0, 6'h00);
    add(1, 1, 6'h30, 0, 6'h00, 6'h30, 0, 6'h00);  // redirect with pop+capture
    add(1, 0, 6'h00, 0, 6'h00, 6'h31, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h30, 6'h32, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h31, 6'h33, 0, 6'h00);
    add(1, 1, 6'h10, 0, 6'h00, 6'h10, 0, 6'h00);  // back-to-back redirects
    add(1, 1, 6'h3e, 0, 6'h00, 6'h3e, 0, 6'h00);
    add(1, 0, 6'h00, 0, 6'h00, 6'h3f, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h3e, 6'h00, 0, 6'h00);  // pc wraps
    add(1, 0, 6'h00, 1, 6'h3f, 6'h01, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h00, 6'h02, 0, 6'h00);
    add(1, 0, 6'h00, 1, 6'h01, 6'h03, 0, 6'h00);

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", 32'(if_pc), 32'd0);
    check("rst_instr", 32'(if_instr), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_addr_b", 32'(addr_b), 32'h3f);

    rst = 1'b1;
    load_stream(6'h00);
    for (int i = 0; i < vecs.size(); i++) begin
      if_ready       = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_addr  = vecs[i].raddr;
      step();
      check($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_addr", i), 32'(addr_a), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), 32'(if_pc), 32'(vecs[i].exp_pc));
        check($sformatf("v%0d_instr", i), 32'(if_instr), 32'(mem_val(vecs[i].exp_pc)));
      end
      if (vecs[i].chk_b) begin
        check($sformatf("v%0d_b_valid", i), 32'(valid_b), 32'd1);
        check($sformatf("v%0d_b_pc", i), 32'(pc_b), 32'(vecs[i].exp_pc_b));
        check($sformatf("v%0d_b_instr", i), 32'(instr_out_b), 32'(mem_val(vecs[i].exp_pc_b)));
      end
    end

    // asynchronous reset between edges while streaming
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_pc", 32'(if_pc), 32'd0);
    check("async_addr", 32'(addr_a), 32'd0);
    check("async_valid_b", 32'(valid_b), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    load_stream(6'h00);
    step();
    check("restart_valid0", 32'(if_valid), 32'd0);
    step();
    check("restart_valid1", 32'(if_valid), 32'd1);
    check("restart_pc", 32'(if_pc), 32'd0);
    check("restart_instr", 32'(if_instr), 32'h0100);
    check("restart_pc_b", 32'(pc_b), 32'h3f);
    step();
    check("restart_pc1", 32'(if_pc), 32'd1);
    step();
    check("restart_pc2", 32'(if_pc), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
